// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch and the load/store unit.
// Optional IF anti-starvation counter enabled with `define ARB_STARVE_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_stall,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_bmask,
  output logic                lsu_done,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_bmask,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state, state_next;
  logic               owner_lsu;
  logic               lat_we;
  logic [CNT_W-1:0]   lat_cnt;
  logic               grant_any;
  logic               grant_lsu;
  logic               force_if;

`ifdef ARB_STARVE_EN
  localparam int SW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

  logic [SW-1:0] starve_cnt;

  assign force_if = if_req && (starve_cnt >= SW'(STARVE_MAX));

  // Counts back-to-back LSU wins that left a pending fetch waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == IDLE && grant_any) begin
      if (grant_lsu && if_req) starve_cnt <= starve_cnt + SW'(1);
      else                     starve_cnt <= '0;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  assign grant_any = if_req | lsu_req;
  assign grant_lsu = lsu_req & ~force_if;

  assign if_stall  = if_req  & ~if_done;
  assign lsu_stall = lsu_req & ~lsu_done;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = ISSUE;
      ISSUE:   state_next = lat_we ? DONE : WAIT;
      WAIT:    if (lat_cnt == CNT_W'(MEM_LAT)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Strobes default low each cycle so mem_req and the done pulses last exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_lsu <= 1'b0;
      lat_we    <= 1'b0;
      lat_cnt   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_bmask <= '0;
      if_done   <= 1'b0;
      if_rdata  <= '0;
      lsu_done  <= 1'b0;
      lsu_rdata <= '0;
    end else begin
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      if_done  <= 1'b0;
      lsu_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner_lsu <= grant_lsu;
            mem_req   <= 1'b1;
            if (grant_lsu) begin
              lat_we    <= lsu_we;
              mem_we    <= lsu_we;
              mem_addr  <= lsu_addr;
              mem_wdata <= lsu_we ? lsu_wdata : '0;
              mem_bmask <= lsu_we ? lsu_bmask : '0;
            end else begin
              lat_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_bmask <= '0;
            end
          end
        end
        ISSUE: begin
          lat_cnt <= CNT_W'(1);
          if (lat_we) begin
            lsu_done  <= 1'b1;
            lsu_rdata <= '0;
          end
        end
        WAIT: begin
          if (lat_cnt == CNT_W'(MEM_LAT)) begin
            if (owner_lsu) begin
              lsu_rdata <= mem_rdata;
              lsu_done  <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the pipeline's fetch stage (IF) and its load/store unit (LSU, MEM stage).
- Arbitrates between the two requesters, sequences each memory transaction through a fixed-latency FSM, and returns read data with a one-cycle done pulse.
- Drives per-requester stall outputs into the pipeline's hazard logic.
- Sits between pipeline_forward's IF/MEM stages and the memory macro, in the same clock domain.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; byte mask width is DATA_W/8.
- MEM_LAT, 1, memory read latency in cycles from mem_req high to mem_rdata valid; must be >= 1.
- STARVE_MAX, 4, consecutive LSU grants allowed while IF is pending (used only with ARB_STARVE_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, level; held until if_done
- if_addr  in  ADDR_W  fetch address
- if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- if_stall  out  1  if_req & ~if_done
- lsu_req  in  1  load/store request, level; held until lsu_done
- lsu_we  in  1  1 = store, 0 = load
- lsu_addr  in  ADDR_W  load/store address
- lsu_wdata  in  DATA_W  store data
- lsu_bmask  in  DATA_W/8  store byte enables
- lsu_done  out  1  one-cycle pulse: access complete
- lsu_rdata  out  DATA_W  load data; 0 for stores
- lsu_stall  out  1  lsu_req & ~lsu_done
- mem_req  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_bmask  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_req

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if any req is high, latch the winner's owner, we, addr, wdata, bmask, then go to ISSUE.
  - ISSUE: mem_* driven from the latched fields with mem_req=1 for exactly one cycle. Then WAIT for loads/fetches, DONE for stores.
  - WAIT: a counter counts MEM_LAT cycles after ISSUE. On the cycle mem_rdata is valid, capture it into the owner's rdata register and go to DONE.
  - DONE: pulse the owner's done for one cycle, then return to IDLE.
- Outputs are registered except the two stall signals, which are combinational from req and done.
- Priority: LSU wins over IF when both are pending, because the MEM-stage instruction is older.
- Latency, with request first seen in IDLE at cycle t:
  - Read/fetch: done at t+MEM_LAT+2.
  - Store: done at t+2.
- Throughput: one transaction per MEM_LAT+3 cycles for reads, including the IDLE arbitration cycle.
- A req dropped mid-transaction does not abort it. The transaction completes and done still pulses; the requester ignores it.
- Changing addr/data while req is held has no effect after the IDLE latch cycle.
- The non-owner's rdata holds its last value.
- mem_wdata and mem_bmask are 0 for reads. lsu_rdata is written 0 on a store completion.
- Reset (asynchronous, any state): FSM to IDLE; all registered outputs, latched fields, counters and rdata registers to 0. An in-flight transaction is discarded with no done pulse. A memory response arriving after reset release is ignored.

Optional Feature:
- Macro: ARB_STARVE_EN.
- Defined:
  - A 3-bit-or-wider counter counts consecutive LSU grants made while if_req was high.
  - When the count reaches STARVE_MAX, the next arbitration with if_req high grants IF even if lsu_req is high, and the counter clears.
  - The counter also clears on any IF grant and on reset.
- Undefined: strict LSU priority, and no counter logic is present.

Test Plan:
1. Fetch only, MEM_LAT=1: if_req=1, if_addr=0x0000_0010 at t, memory returns 0x0051_0093. Required: mem_req at t+1 with addr 0x10, if_done at t+3, if_rdata=0x0051_0093, if_stall high from t to t+2.
2. Store: lsu_we=1, addr 0x0000_7000, wdata 0xDEAD_BEEF, bmask 0xF at t. Required: mem_we=1 with matching fields at t+1, lsu_done at t+2, lsu_rdata=0.
3. Contention: if_req and a load (addr 0x20, memory returns 0x1234_5678) asserted together at t. Required: LSU served first (lsu_done t+3). IF then latched at t+4, mem_req t+5, if_done t+7; if_stall high throughout.
4. MEM_LAT=3 load at t. Required: lsu_done exactly at t+5, and mem_req high for one cycle only.
5. Reset mid-operation: rst_n low during WAIT of a fetch. Required: all outputs 0 immediately, no if_done afterwards, and a fresh request after release completes normally.
6. ARB_STARVE_EN defined, STARVE_MAX=4: lsu_req and if_req held continuously. Required: grant order LSU, LSU, LSU, LSU, IF, LSU…
